// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Helpers shared by the fifo_lvl slice:
//   ptr_inc  - wrap-around pointer increment that works for any depth
//   fifo_cap - total capacity (array entries plus optional output flop)
//   fifo_cw  - width of an occupancy count able to hold 0..cap
// -----------------------------------------------------------------------------
package fifo_pkg;

    // Explicit compare against depth-1 rather than relying on natural
    // overflow, so non-power-of-two depths wrap correctly.
    function automatic int unsigned ptr_inc(input int unsigned ptr,
                                            input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

    function automatic int fifo_cap(input int depth, input int out_reg);
        return depth + ((out_reg != 0) ? 1 : 0);
    endfunction

    function automatic int fifo_cw(input int cap);
        return $clog2(cap + 1);
    endfunction

endpackage

// File: rtl/fifo_lvl_if.sv
// -----------------------------------------------------------------------------
// fifo_lvl_if
// Streaming handshake bundle for fifo_lvl: write side (data_in/_val/_rdy) and
// read side (data_out/_val/_rdy).
//   slave  - the FIFO's view (accepts writes, presents reads)
//   master - the surrounding logic's view (producer and consumer)
// -----------------------------------------------------------------------------
interface fifo_lvl_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_in;
    logic             data_in_val;
    logic             data_in_rdy;
    logic [WIDTH-1:0] data_out;
    logic             data_out_val;
    logic             data_out_rdy;

    modport slave (
        input  data_in, data_in_val, data_out_rdy,
        output data_in_rdy, data_out, data_out_val
    );

    modport master (
        output data_in, data_in_val, data_out_rdy,
        input  data_in_rdy, data_out, data_out_val
    );
endinterface

// File: rtl/fifo_out_reg.sv
// -----------------------------------------------------------------------------
// fifo_out_reg
// Registered output stage of fifo_lvl (used when OUT_REG=1).
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   flush       - invalidate the stage
//   ld_arr      - load head word from the storage array
//   ld_byp      - load the incoming write word directly (array empty)
//   pop         - consumer takes the current word
//   arr_data    - storage array head word
//   in_data     - write-side data
//   vld, data   - stage contents presented as data_out_val / data_out
// -----------------------------------------------------------------------------
module fifo_out_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             ld_arr,
    input  logic             ld_byp,
    input  logic             pop,
    input  logic [WIDTH-1:0] arr_data,
    input  logic [WIDTH-1:0] in_data,
    output logic             vld,
    output logic [WIDTH-1:0] data
);

    // A load always wins over a pop: the caller only loads when the stage is
    // empty or being emptied this cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            vld <= 1'b0;
        end else if (ld_arr || ld_byp) begin
            vld <= 1'b1;
        end else if (pop) begin
            vld <= 1'b0;
        end
    end

    // Data only changes on a load, so it holds while stalled.
    always_ff @(posedge clk) begin
        if (ld_arr) begin
            data <= arr_data;
        end else if (ld_byp) begin
            data <= in_data;
        end
    end

endmodule

// File: rtl/fifo_lvl.sv
// -----------------------------------------------------------------------------
// fifo_lvl
// First-word-fall-through FIFO of any depth with occupancy count, almost
// thresholds, synchronous flush, optional registered output and sticky
// overflow/underflow flags.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   flush         - synchronous discard of all contents
//   bus           - fifo_lvl_if.slave: data_in/_val/_rdy, data_out/_val/_rdy
//   count         - occupancy, includes output flop when OUT_REG=1
//   empty, full   - count==0, count==CAP
//   almost_empty  - count <= AE_THRESH
//   almost_full   - count >= AF_THRESH
//   overflow      - sticky: write attempted while full
//   underflow     - sticky: read attempted while nothing valid
// -----------------------------------------------------------------------------
module fifo_lvl
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int OUT_REG   = 0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          flush,
    fifo_lvl_if.slave                                     bus,
    output logic [fifo_cw(fifo_cap(DEPTH, OUT_REG))-1:0]  count,
    output logic                                          empty,
    output logic                                          full,
    output logic                                          almost_empty,
    output logic                                          almost_full,
    output logic                                          overflow,
    output logic                                          underflow
);

    localparam int CAP = fifo_cap(DEPTH, OUT_REG);
    localparam int CW  = fifo_cw(CAP);
    localparam int PW  = $clog2(DEPTH);

    if (DEPTH < 2) begin : g_bad_depth
        $error("fifo_lvl: DEPTH must be at least 2");
    end
    if (AE_THRESH >= CAP) begin : g_bad_ae
        $error("fifo_lvl: AE_THRESH must be below capacity");
    end
    if (AF_THRESH < 1 || AF_THRESH > CAP) begin : g_bad_af
        $error("fifo_lvl: AF_THRESH must be within 1..capacity");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;

    logic             push;
    logic             pop;
    logic             arr_wr;
    logic             arr_rd;
    logic             out_val;
    logic [WIDTH-1:0] out_data;

    // Flags come straight from the count register, never from the handshake
    // inputs, so ready/valid have no combinational input dependency.
    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(CAP));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign almost_full  = (count_q >= CW'(AF_THRESH));

    assign bus.data_in_rdy  = ~full;
    assign bus.data_out_val = out_val;
    assign bus.data_out     = out_data;

    // Transfers that actually take effect; flush overrides both.
    assign push = bus.data_in_val  & ~full   & ~flush;
    assign pop  = bus.data_out_rdy & out_val & ~flush;

    if (OUT_REG == 0) begin : g_comb_out
        assign out_val  = ~empty;
        assign out_data = mem[rd_ptr];
        assign arr_wr   = push;
        assign arr_rd   = pop;
    end else begin : g_reg_out
        logic arr_empty;
        logic stage_free;
        logic ld_arr;
        logic ld_byp;

        // The output flop is only ever empty when the array is also empty,
        // so array occupancy is count minus the flop's valid bit.
        assign arr_empty  = (count_q == CW'(out_val));
        assign stage_free = ~out_val | pop;
        assign ld_arr     = stage_free & ~arr_empty & ~flush;
        // Nothing queued ahead: the write goes straight to the output flop.
        assign ld_byp     = stage_free & arr_empty & push;
        assign arr_rd     = ld_arr;
        assign arr_wr     = push & ~ld_byp;

        fifo_out_reg #(
            .WIDTH (WIDTH)
        ) u_out_reg (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .ld_arr   (ld_arr),
            .ld_byp   (ld_byp),
            .pop      (pop),
            .arr_data (mem[rd_ptr]),
            .in_data  (bus.data_in),
            .vld      (out_val),
            .data     (out_data)
        );
    end

    // Storage array: contents are never reset.
    always_ff @(posedge clk) begin
        if (arr_wr && !reset) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (arr_wr) begin
                wr_ptr <= PW'(ptr_inc(32'(wr_ptr), DEPTH));
            end
            if (arr_rd) begin
                rd_ptr <= PW'(ptr_inc(32'(rd_ptr), DEPTH));
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky protocol error flags; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (bus.data_in_val && full) begin
                overflow <= 1'b1;
            end
            if (bus.data_out_rdy && !out_val) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule
